vx_barrier_ctrl: RTL and testbench



---
 rtl/vx_barrier_ctrl_if.sv | 32 +++
 rtl/vx_barrier_ctrl.sv | 103 ++++++++++
 tb/tb_vx_barrier_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/vx_barrier_ctrl_if.sv
// Barrier request/response bundle between the warp-control stage, the barrier
// scheduler and the warp scheduler.
interface vx_barrier_ctrl_if #(
    parameter int unsigned NUM_WARPS    = 4,
    parameter int unsigned NUM_BARRIERS = 4
);
    localparam int unsigned NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int unsigned NB_WIDTH = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

    logic                    bar_valid;
    logic [NW_WIDTH-1:0]     bar_wid;
    logic [NB_WIDTH-1:0]     bar_id;
    logic [NW_WIDTH-1:0]     bar_size_m1;
    logic                    bar_is_noop;
    logic                    abort_valid;
    logic [NW_WIDTH-1:0]     abort_wid;
    logic                    stall_valid;
    logic [NW_WIDTH-1:0]     stall_wid;
    logic                    release_valid;
    logic [NUM_WARPS-1:0]    release_wmask;
    logic [NUM_BARRIERS-1:0] busy_mask;

    modport master (
        output bar_valid, bar_wid, bar_id, bar_size_m1, bar_is_noop, abort_valid, abort_wid,
        input  stall_valid, stall_wid, release_valid, release_wmask, busy_mask
    );

    modport slave (
        input  bar_valid, bar_wid, bar_id, bar_size_m1, bar_is_noop, abort_valid, abort_wid,
        output stall_valid, stall_wid, release_valid, release_wmask, busy_mask
    );
endinterface

// File: rtl/vx_barrier_ctrl.sv
// Local warp-barrier scheduler: counts arrivals per barrier ID, stalls arriving
// warps and releases all waiters once the arrival count is met.
module vx_barrier_ctrl #(
    parameter int unsigned NUM_WARPS    = 4,
    parameter int unsigned NUM_BARRIERS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_barrier_ctrl_if.slave     bus
);
    localparam int unsigned NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic [NW_WIDTH-1:0]     count_q   [NUM_BARRIERS];
    logic [NW_WIDTH-1:0]     count_d   [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    waiters_q [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    waiters_d [NUM_BARRIERS];

    logic                    stall_valid_q, stall_valid_d;
    logic [NW_WIDTH-1:0]     stall_wid_q, stall_wid_d;
    logic                    release_valid_q, release_valid_d;
    logic [NUM_WARPS-1:0]    release_wmask_q, release_wmask_d;
    logic [NUM_BARRIERS-1:0] busy_q, busy_d;
    logic                    dup;

    always_comb begin
        count_d         = count_q;
        waiters_d       = waiters_q;
        stall_valid_d   = 1'b0;
        stall_wid_d     = '0;
        release_valid_d = 1'b0;
        release_wmask_d = '0;
        busy_d          = '0;
        dup             = 1'b0;

        // Abort is resolved first so the arrival sees the purged state.
        if (bus.abort_valid) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                if (waiters_q[i][bus.abort_wid]) begin
                    waiters_d[i][bus.abort_wid] = 1'b0;
                    count_d[i]                  = count_q[i] - NW_WIDTH'(1);
                end
            end
        end

        if (bus.bar_valid && !bus.bar_is_noop && (32'(bus.bar_id) < NUM_BARRIERS)
            && !(bus.abort_valid && (bus.abort_wid == bus.bar_wid))) begin
            dup = waiters_d[bus.bar_id][bus.bar_wid];
            if (!dup) begin
                // ">=" lets a shrunk size complete the barrier immediately.
                if (count_d[bus.bar_id] >= bus.bar_size_m1) begin
                    release_valid_d         = 1'b1;
                    release_wmask_d         = waiters_d[bus.bar_id];
                    waiters_d[bus.bar_id]   = '0;
                    count_d[bus.bar_id]     = '0;
                end else begin
                    count_d[bus.bar_id]                = count_d[bus.bar_id] + NW_WIDTH'(1);
                    waiters_d[bus.bar_id][bus.bar_wid] = 1'b1;
                    stall_valid_d                      = 1'b1;
                    stall_wid_d                        = bus.bar_wid;
                end
            end
        end

        for (int i = 0; i < NUM_BARRIERS; i++) begin
            busy_d[i] = |waiters_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                count_q[i]   <= '0;
                waiters_q[i] <= '0;
            end
            stall_valid_q   <= 1'b0;
            stall_wid_q     <= '0;
            release_valid_q <= 1'b0;
            release_wmask_q <= '0;
            busy_q          <= '0;
        end else begin
            count_q         <= count_d;
            waiters_q       <= waiters_d;
            stall_valid_q   <= stall_valid_d;
            stall_wid_q     <= stall_wid_d;
            release_valid_q <= release_valid_d;
            release_wmask_q <= release_wmask_d;
            busy_q          <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!dup)
            else $warning("duplicate barrier arrival: wid=%0d id=%0d", bus.bar_wid, bus.bar_id);
        end
    end

    assign bus.stall_valid   = stall_valid_q;
    assign bus.stall_wid     = stall_wid_q;
    assign bus.release_valid = release_valid_q;
    assign bus.release_wmask = release_wmask_q;
    assign bus.busy_mask     = busy_q;
endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Self-checking bench for vx_barrier_ctrl: directed scenarios plus randomized
// traffic checked against a set-based barrier model.
module tb_vx_barrier_ctrl;
    localparam int NW = 4;
    localparam int NB = 4;

    typedef struct packed {
        bit          v;
        int          wid;
        int          id;
        int          sz;
        bit          noop;
        bit          av;
        int          awid;
        logic [11:0] exp;  // {stall_valid, stall_wid, release_valid, release_wmask, busy_mask}
    } row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    vx_barrier_ctrl_if #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) bif ();

    vx_barrier_ctrl #(.NUM_WARPS(NW), .NUM_BARRIERS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {bif.stall_valid, bif.stall_wid, bif.release_valid, bif.release_wmask,
                bif.busy_mask};
    endfunction

    // Called at a negedge; returns at the next negedge with outputs for this input.
    task automatic drive(input bit v, input int wid, input int id, input int sz,
                         input bit noop, input bit av, input int awid);
        bif.bar_valid   = v;
        bif.bar_wid     = 2'(wid);
        bif.bar_id      = 2'(id);
        bif.bar_size_m1 = 2'(sz);
        bif.bar_is_noop = noop;
        bif.abort_valid = av;
        bif.abort_wid   = 2'(awid);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 1, 1, 2, 0, 0, 0);
        drive(1, 2, 1, 2, 0, 0, 0);
        reset = 1'b0;
        bif.bar_valid = 1'b0;
        n_tests++;
        if (outs() !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp %b", outs(), 12'b0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (outs() !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_idle got %b exp %b", outs(), 12'b0);
        end
    endtask

    task automatic test_completion();
        row_t r[4] = '{
            '{1, 0, 1, 2, 0, 0, 0, 12'b1_00_0_0000_0010},
            '{1, 2, 1, 2, 0, 0, 0, 12'b1_10_0_0000_0010},
            '{1, 3, 1, 2, 0, 0, 0, 12'b0_00_1_0101_0000},
            '{0, 0, 0, 0, 0, 0, 0, 12'b0}};
        for (int k = 0; k < 4; k++) begin
            drive(r[k].v, r[k].wid, r[k].id, r[k].sz, r[k].noop, r[k].av, r[k].awid);
            n_tests++;
            if (outs() !== r[k].exp) begin
                n_fail++;
                $display("FAIL completion step%0d got %b exp %b", k, outs(), r[k].exp);
            end
        end
    endtask

    task automatic test_noop();
        row_t r[2] = '{
            '{1, 1, 2, 0, 1, 0, 0, 12'b0},
            '{1, 1, 2, 0, 0, 0, 0, 12'b0_00_1_0000_0000}};
        for (int k = 0; k < 2; k++) begin
            drive(r[k].v, r[k].wid, r[k].id, r[k].sz, r[k].noop, r[k].av, r[k].awid);
            n_tests++;
            if (outs() !== r[k].exp) begin
                n_fail++;
                $display("FAIL noop_size1 step%0d got %b exp %b", k, outs(), r[k].exp);
            end
        end
    endtask

    task automatic test_abort();
        row_t r[8] = '{
            '{1, 1, 0, 2, 0, 0, 0, 12'b1_01_0_0000_0001},
            '{1, 2, 0, 2, 0, 0, 0, 12'b1_10_0_0000_0001},
            '{0, 0, 0, 0, 0, 1, 1, 12'b0_00_0_0000_0001},
            '{1, 3, 0, 2, 0, 0, 0, 12'b1_11_0_0000_0001},
            '{1, 0, 0, 2, 0, 0, 0, 12'b0_00_1_1100_0000},
            // abort of the arriving warp drops the arrival
            '{1, 1, 0, 1, 0, 1, 1, 12'b0},
            '{1, 2, 0, 1, 0, 0, 0, 12'b1_10_0_0000_0001},
            '{0, 0, 0, 0, 0, 1, 2, 12'b0}};
        for (int k = 0; k < 8; k++) begin
            drive(r[k].v, r[k].wid, r[k].id, r[k].sz, r[k].noop, r[k].av, r[k].awid);
            n_tests++;
            if (outs() !== r[k].exp) begin
                n_fail++;
                $display("FAIL abort step%0d got %b exp %b", k, outs(), r[k].exp);
            end
        end
    endtask

    task automatic test_concurrent();
        row_t r[4] = '{
            '{1, 0, 0, 1, 0, 0, 0, 12'b1_00_0_0000_0001},
            '{1, 1, 3, 1, 0, 0, 0, 12'b1_01_0_0000_1001},
            '{1, 2, 3, 1, 0, 0, 0, 12'b0_00_1_0010_0001},
            '{1, 3, 0, 1, 0, 0, 0, 12'b0_00_1_0001_0000}};
        for (int k = 0; k < 4; k++) begin
            drive(r[k].v, r[k].wid, r[k].id, r[k].sz, r[k].noop, r[k].av, r[k].awid);
            n_tests++;
            if (outs() !== r[k].exp) begin
                n_fail++;
                $display("FAIL concurrent step%0d got %b exp %b", k, outs(), r[k].exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        row_t r[5] = '{
            '{1, 0, 2, 3, 0, 0, 0, 12'b1_00_0_0000_0100},
            '{1, 1, 2, 3, 0, 0, 0, 12'b1_01_0_0000_0100},
            '{0, 0, 0, 0, 0, 0, 0, 12'b0},
            '{1, 2, 2, 1, 0, 0, 0, 12'b1_10_0_0000_0100},
            '{1, 3, 2, 1, 0, 0, 0, 12'b0_00_1_0100_0000}};
        for (int k = 0; k < 5; k++) begin
            reset = (k == 2);
            drive(r[k].v, r[k].wid, r[k].id, r[k].sz, r[k].noop, r[k].av, r[k].awid);
            n_tests++;
            if (outs() !== r[k].exp) begin
                n_fail++;
                $display("FAIL mid_reset step%0d got %b exp %b", k, outs(), r[k].exp);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_duplicate();
        row_t r[3] = '{
            '{1, 0, 1, 3, 0, 0, 0, 12'b1_00_0_0000_0010},
            '{1, 0, 1, 3, 0, 0, 0, 12'b0_00_0_0000_0010},
            '{1, 1, 1, 1, 0, 0, 0, 12'b0_00_1_0001_0000}};
        for (int k = 0; k < 3; k++) begin
            drive(r[k].v, r[k].wid, r[k].id, r[k].sz, r[k].noop, r[k].av, r[k].awid);
            n_tests++;
            if (outs() !== r[k].exp) begin
                n_fail++;
                $display("FAIL duplicate step%0d got %b exp %b", k, outs(), r[k].exp);
            end
        end
    endtask

    // Model: each barrier is a set of waiting warps; its count is the set size.
    task automatic test_back_to_back_random();
        bit [NW-1:0] mw [NB];
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < NB; i++) mw[i] = '0;
        for (int n = 0; n < 400; n++) begin
            bit          av, v, noop, waiting;
            int          awid, wid, id, sz;
            logic [11:0] exp;
            bit          sv, rv;
            int          sw;
            bit [NW-1:0] rm;
            bit [NB-1:0] busy;
            av   = ($urandom_range(3) == 0);
            awid = $urandom_range(NW - 1);
            if (av) for (int i = 0; i < NB; i++) mw[i][awid] = 1'b0;
            wid     = $urandom_range(NW - 1);
            id      = $urandom_range(NB - 1);
            sz      = $urandom_range(NW - 1);
            noop    = ($urandom_range(7) == 0);
            waiting = 1'b0;
            for (int i = 0; i < NB; i++) waiting |= mw[i][wid];
            v  = ($urandom_range(3) != 0) && !waiting;
            sv = 0; rv = 0; sw = 0; rm = '0;
            if (v && !noop && !(av && awid == wid)) begin
                if ($countones(mw[id]) >= sz) begin
                    rv     = 1;
                    rm     = mw[id];
                    mw[id] = '0;
                end else begin
                    mw[id][wid] = 1'b1;
                    sv          = 1;
                    sw          = wid;
                end
            end
            for (int i = 0; i < NB; i++) busy[i] = |mw[i];
            exp = {sv, 2'(sw), rv, rm, busy};
            drive(v, wid, id, sz, noop, av, awid);
            n_tests++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL random cycle%0d got %b exp %b", n, outs(), exp);
            end
        end
    endtask

    initial begin
        bif.bar_valid   = 1'b0;
        bif.bar_wid     = '0;
        bif.bar_id      = '0;
        bif.bar_size_m1 = '0;
        bif.bar_is_noop = 1'b0;
        bif.abort_valid = 1'b0;
        bif.abort_wid   = '0;
        @(negedge clk);
        test_reset();
        test_completion();
        test_noop();
        test_abort();
        test_concurrent();
        test_mid_reset();
        test_duplicate();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
